// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder for an RV32I load/store unit.
// Each request is captured in IDLE, executed in ACCESS and answered in RESP.
// At most one request is outstanding.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word
// accesses into errors. Without it, misaligned low address bits are ignored.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic   accept;

  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic             illegalOp;
  logic             outOfRange;
  logic             misaligned;
  logic             accessErr;
  logic [IDX_W-1:0] memIdx;
  logic [31:0]      memRdWord;
  logic [31:0]      memWrData;
  logic             memWe;
  logic [3:0]       byteEn;
  logic [31:0]      wrWord;
  logic [7:0]       loadByte;
  logic [15:0]      loadHalf;
  logic [31:0]      loadData;

  // State register; reset drops any in-flight access or pending response at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs for the IDLE -> ACCESS -> RESP cycle.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request fault detection, evaluated only on the captured request fields.
  always_comb begin
    illegalOp  = 1'b0;
    misaligned = 1'b0;
    case (funct3_q)
      3'b011, 3'b110, 3'b111: illegalOp = 1'b1;
      3'b100, 3'b101:         illegalOp = we_q;
      default:                illegalOp = 1'b0;
    endcase
    outOfRange = (addr_q[31:AW] != '0);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (funct3_q[1:0] == 2'b01) begin
      misaligned = addr_q[0];
    end else if (funct3_q[1:0] == 2'b10) begin
      misaligned = (addr_q[1:0] != 2'b00);
    end
`endif
    accessErr = illegalOp | outOfRange | misaligned;
    memIdx    = addr_q[AW-1:2];
  end

  // Store lane selection: replicate the store data and enable only the addressed lanes.
  always_comb begin
    byteEn = 4'b0000;
    wrWord = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byteEn = 4'b0001 << addr_q[1:0];
        wrWord = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byteEn = addr_q[1] ? 4'b1100 : 4'b0011;
        wrWord = {2{wdata_q[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrWord = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      memWrData[8*i +: 8] = byteEn[i] ? wrWord[8*i +: 8] : memRdWord[8*i +: 8];
    end
    memWe = (state_q == ACCESS) && we_q && !accessErr;
  end

  // Storage array, optionally zero-filled at elaboration; reset never touches it.
  if (INIT_ZERO != 0) begin : g_mem
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

    // Commit the merged word at the end of a legal store's ACCESS cycle.
    always_ff @(posedge clk) begin
      if (memWe) begin
        mem_q[memIdx] <= memWrData;
      end
    end

    assign memRdWord = mem_q[memIdx];
  end else begin : g_mem
    logic [31:0] mem_q [DEPTH_WORDS];

    // Commit the merged word at the end of a legal store's ACCESS cycle.
    always_ff @(posedge clk) begin
      if (memWe) begin
        mem_q[memIdx] <= memWrData;
      end
    end

    assign memRdWord = mem_q[memIdx];
  end

  // Load formatting: little-endian lane pick followed by sign or zero extension.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   loadByte = memRdWord[7:0];
      2'b01:   loadByte = memRdWord[15:8];
      2'b10:   loadByte = memRdWord[23:16];
      default: loadByte = memRdWord[31:24];
    endcase
    loadHalf = addr_q[1] ? memRdWord[31:16] : memRdWord[15:0];
    case (funct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  loadData = memRdWord;
      3'b100:  loadData = {24'h0, loadByte};
      3'b101:  loadData = {16'h0, loadHalf};
      default: loadData = 32'h0;
    endcase
  end

  // Next values for the capture and response registers.
  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end
    if (state_q == ACCESS) begin
      rdata_d = (we_q || accessErr) ? 32'h0 : loadData;
      err_d   = accessErr;
    end
  end

  // Capture and response registers; the response holds until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with hand-computed expected values.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checkCount;
  int passCount;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_DATA = 32'h0;
  localparam logic        MIS_ERR  = 1'b1;
`else
  localparam logic [31:0] MIS_DATA = 32'h7FADBEEF;
  localparam logic        MIS_ERR  = 1'b0;
`endif

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .INIT_ZERO(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something deadlocks.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic driveReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic clearReq();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
  endtask

  // One full transaction with rsp_ready high: checks accept, latency, data and error.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr);
    int lat;
    @(negedge clk);
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'h1);
    driveReq(we, f3, addr, wdata);
    @(posedge clk);
    #1;
    clearReq();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    checkOutput({tag, ".latency"}, 32'(lat), 32'd2);
    checkOutput({tag, ".rdata"}, rsp_rdata, expData);
    checkOutput({tag, ".err"}, 32'(rsp_err), 32'(expErr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    rsp_ready  = 1'b1;
    clearReq();

    #12;
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset.rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.req_ready", 32'(req_ready), 32'h1);

    // Basic word store/load and reference data for later checks.
    applyStimulus("sw0", 1'b1, LW, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    applyStimulus("sw10", 1'b1, LW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus("lw10", 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store and sub-word loads with sign/zero extension.
    applyStimulus("sb13", 1'b1, LB, 32'h13, 32'hFFFFFF7F, 32'h0, 1'b0);
    applyStimulus("lb13", 1'b0, LB, 32'h13, 32'h0, 32'h0000007F, 1'b0);
    applyStimulus("lbu11", 1'b0, LBU, 32'h11, 32'h0, 32'h000000BE, 1'b0);
    applyStimulus("lb11", 1'b0, LB, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
    applyStimulus("lh12", 1'b0, LH, 32'h12, 32'h0, 32'h00007FAD, 1'b0);
    applyStimulus("lh10", 1'b0, LH, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    applyStimulus("lhu10", 1'b0, LHU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    applyStimulus("lw12", 1'b0, LW, 32'h12, 32'h0, MIS_DATA, MIS_ERR);

    // Illegal encodings: error, zero data, no write.
    applyStimulus("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    applyStimulus("st100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
    applyStimulus("lw10b", 1'b0, LW, 32'h10, 32'h0, 32'h7FADBEEF, 1'b0);

    // Halfword store into a scratch word.
    applyStimulus("sw30", 1'b1, LW, 32'h30, 32'h11223344, 32'h0, 1'b0);
    applyStimulus("sh32", 1'b1, LH, 32'h32, 32'hFFFFA5A5, 32'h0, 1'b0);
    applyStimulus("lw30", 1'b0, LW, 32'h30, 32'h0, 32'hA5A53344, 1'b0);

    // Address range boundary.
    applyStimulus("swTop", 1'b1, LW, 32'hFFC, 32'h01020304, 32'h0, 1'b0);
    applyStimulus("lwTop", 1'b0, LW, 32'hFFC, 32'h0, 32'h01020304, 1'b0);
    applyStimulus("swOor", 1'b1, LW, 32'h1000, 32'h11111111, 32'h0, 1'b1);
    applyStimulus("lwOor", 1'b0, LW, 32'h1000, 32'h0, 32'h0, 1'b1);
    applyStimulus("lw0", 1'b0, LW, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

    // Response backpressure: output holds and new requests are ignored.
    rsp_ready = 1'b0;
    @(negedge clk);
    driveReq(1'b0, LW, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    driveReq(1'b1, LW, 32'h10, 32'hBADBAD00);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("hold.rsp_rdata", rsp_rdata, 32'h7FADBEEF);
      checkOutput("hold.req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    clearReq();
    @(posedge clk);
    #1;
    checkOutput("hold.released", 32'(rsp_valid), 32'h0);
    applyStimulus("lw10c", 1'b0, LW, 32'h10, 32'h0, 32'h7FADBEEF, 1'b0);

    // Reset during ACCESS suppresses the store.
    applyStimulus("sw20", 1'b1, LW, 32'h20, 32'hAAAA5555, 32'h0, 1'b0);
    @(negedge clk);
    driveReq(1'b1, LW, 32'h20, 32'h12345678);
    @(posedge clk);
    #1;
    clearReq();
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstAcc.rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstAcc.rsp_err", 32'(rsp_err), 32'h0);
    applyStimulus("lw20", 1'b0, LW, 32'h20, 32'h0, 32'hAAAA5555, 1'b0);

    // Reset during RESP drops the pending response immediately.
    rsp_ready = 1'b0;
    @(negedge clk);
    driveReq(1'b0, LW, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    clearReq();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstRsp.pre_valid", 32'(rsp_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstRsp.rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rstRsp.rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstRsp.req_ready", 32'(req_ready), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter INIT_ZERO, default 1, meaning 1 clears the storage array at elaboration.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents a load/store.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width/sign code (lb/lh/lw/lbu/lhu; sb/sh/sw).
REQ-009 SHALL have port req_addr  input  32  byte address (datapath ALU result).
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (datapath rs2 value).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  requester consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  access faulted (bad funct3, out of range, misaligned when enabled).

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one request outstanding at most.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready, all req_* fields captured into registers.
REQ-017 SHALL, in ACCESS, perform the storage read or byte-enabled write using captured fields only; requester inputs are ignored outside IDLE.
REQ-018 SHALL assert rsp_valid in RESP, exactly 2 cycles after the accepting edge, holding rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready.
REQ-019 SHALL return to IDLE on the handshake edge; next request accepted no earlier than the following edge (throughput 1 per 3 cycles with rsp_ready tied high).
REQ-020 SHALL index storage by addr[log2(DEPTH_WORDS)+1:2]; addr >= 4*DEPTH_WORDS SHALL give rsp_err=1 with no write.
REQ-021 SHALL for stores write lanes: sb -> byte addr[1:0] gets wdata[7:0]; sh -> halfword addr[1] gets wdata[15:0]; sw -> all 4 bytes; other lanes unchanged.
REQ-022 SHALL for loads select byte/halfword by addr[1:0]/addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through; little-endian.
REQ-023 SHALL treat funct3 011,110,111 (any) and 100,101 with req_we=1 as illegal: rsp_err=1, no write, rsp_rdata=0.
REQ-024 SHALL produce rsp_rdata=0 for every store response.
REQ-025 SHALL, on error, still complete the full IDLE->ACCESS->RESP sequence (no early response).

Reset
REQ-026 SHALL on rst asynchronously force state IDLE, req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request registers 0.
REQ-027 SHALL, if rst asserts during ACCESS, suppress any not-yet-committed write; a write committed on an earlier edge persists; storage contents are never cleared by rst.
REQ-028 SHALL, if rst asserts during RESP, drop the pending response; requester observes rsp_valid=0 immediately.

Configuration
REQ-029 SHALL support macro DMEM_MISALIGN_TRAP_EN: when defined, lh/lhu/sh with addr[0]=1 and lw/sw with addr[1:0]!=0 give rsp_err=1, no write, rsp_rdata=0.
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, silently align: halfword ops ignore addr[0], word ops ignore addr[1:0]; no error raised for alignment.

Verification
REQ-031 SHALL cover: sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept.
REQ-032 SHALL cover: after REQ-031, sb 0x7F @0x13, lb @0x13 -> 0x0000007F; lbu @0x11 -> 0x000000BE; lb @0x11 -> 0xFFFFFFBE; lh @0x12 -> 0x00007FAD.
REQ-033 SHALL cover: lw @0x12 -> with DMEM_MISALIGN_TRAP_EN rsp_err=1, rdata=0; without -> rdata=word @0x10, err=0.
REQ-034 SHALL cover: sw @4*DEPTH_WORDS -> rsp_err=1; subsequent lw @0 returns prior contents unchanged.
REQ-035 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; new req_valid ignored until handshake.
REQ-036 SHALL cover: rst pulsed during ACCESS of sw 0x12345678 @0x20 -> rsp_valid=0, later lw @0x20 returns old value.
